// File: rtl/gate_bist_sequencer.sv
// Exhaustive self-test sequencer for small combinational gate cells: walks every
// input vector, waits a settle time, samples the gate and checks it against TRUTH.
module gate_bist_sequencer #(
    parameter int                       N_IN          = 2,
    parameter logic [(1 << N_IN)-1:0]   TRUTH         = 4'b1000,
    parameter int                       SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    localparam logic [3:0]      CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE    = (N_IN + 1)'(1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
    logic            fail_valid_q, fail_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // Case inequality so an X from the gate under test is reported as a failure.
    assign mismatch = (dut_out !== TRUTH[vec_q]);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d        = '0;
                    cnt_d        = CNT_RELOAD;
                    err_d        = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec_q != LAST_VEC) begin
                    vec_d   = vec_q + VEC_ONE;
                    cnt_d   = CNT_RELOAD;
                    state_d = SETTLE;
                end else begin
                    // Verdict includes the mismatch of this last vector.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    vec_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign vec_out    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

endmodule
